led_blink_driver: RTL and testbench
===================================

LED_BLINK_DRIVER -- requirements
Module: led_blink_driver

Interface
REQ-001 Parameter TICK_DIV, default 16'd50000, CLOCK_50 cycles per 1 ms tick.
REQ-002 Parameter ON_MS, default 16'd250, LED-on phase length in ticks.
REQ-003 Parameter OFF_MS, default 16'd250, LED-off phase length in ticks.
REQ-004 Port CLOCK_50  input  1  system clock; the only clock; all state on its rising edge.
REQ-005 Port reset  input  1  asynchronous, active-high reset.
REQ-006 Port start  input  1  request strobe; sampled every rising edge of CLOCK_50.
REQ-007 Port blinks  input  4  number of on/off cycles requested; sampled with start.
REQ-008 Port led  output  1  registered LED drive, high during ON phase.
REQ-009 Port busy  output  1  registered; high from acceptance until done.
REQ-010 Port done  output  1  registered; one-cycle completion pulse.

Function
REQ-011 States SHALL be IDLE, ON, OFF.
- No other states.
REQ-012 In IDLE, start=1 with blinks!=0 SHALL be accepted.
- The remaining-blink counter SHALL load blinks.
- The tick prescaler and ms counter SHALL clear.
- Next state is ON; led and busy are high from the following cycle.
REQ-013 In IDLE, start=1 with blinks=0 SHALL be ignored.
- No busy, no done.
REQ-014 The prescaler SHALL count 0..TICK_DIV-1 and assert an internal tick on the TICK_DIV-1 cycle.
- It SHALL be held at 0 in IDLE.
REQ-015 ON SHALL last exactly ON_MS*TICK_DIV cycles, then go to OFF.
- ms counter clears on the transition.
REQ-016 OFF SHALL last exactly OFF_MS*TICK_DIV cycles.
- At its end, the remaining-blink counter decrements.
- If the result is nonzero, next state is ON.
- Otherwise next state is IDLE, with done=1 and busy=0 in that same IDLE cycle.
REQ-017 done SHALL be high for exactly one cycle per accepted request.
REQ-018 done SHALL never coincide with busy=1, except as described in REQ-019.
REQ-019 With blinks=15, the sequence SHALL complete 15 full ON/OFF pairs.
- The counter SHALL NOT wrap.
- A start arriving in the done cycle is evaluated in IDLE and may be accepted that cycle; busy then rises the next cycle.
REQ-020 ON_MS or OFF_MS of 0 SHALL be treated as 1 tick.
- A zero-length phase is never produced.
REQ-021 Counters SHALL be 16 bits wide for prescaler and ms count, and 4 bits for remaining blinks.
- No overflow is possible for legal parameters.

Reset
REQ-022 reset=1 SHALL asynchronously force the following, regardless of phase:
- state IDLE
- led=0, busy=0, done=0
- all counters 0
REQ-023 Reset asserted mid-sequence SHALL abort the sequence without a done pulse.
REQ-024 After reset deassertion, the first start SHALL be accepted normally.

Configuration
REQ-025 Macro LED_BLINK_RETRIGGER_EN SHALL control how a start during ON or OFF is handled.
- Defined: start=1 with blinks!=0 during ON or OFF SHALL restart the sequence as in REQ-012.
  - Reload blinks, clear counters, enter ON.
  - No done for the aborted sequence.
- Undefined: start during ON or OFF SHALL be ignored entirely.

Verification
Bench parameters: TICK_DIV=4, ON_MS=2, OFF_MS=3, giving ON=8 cycles and OFF=12 cycles.
REQ-026 Scenario 1, single blink:
- Stimulus: start with blinks=1 at cycle 0.
- Response: led high cycles 1-8, low from 9; busy high cycles 1-20; done high at cycle 21 only.
REQ-027 Scenario 2, three blinks:
- Stimulus: start with blinks=3.
- Response: three 8-cycle led pulses, 20-cycle period; done exactly once, 61 cycles after start.
REQ-028 Scenario 3, zero blinks:
- Stimulus: start with blinks=0.
- Response: led, busy and done stay 0 for 50 cycles.
REQ-029 Scenario 4, reset mid-operation:
- Stimulus: reset pulse at cycle 5 of a blinks=2 sequence.
- Response: led and busy drop asynchronously; no done; a new start with blinks=1 then behaves as Scenario 1.
REQ-030 Scenario 5, start while busy:
- Stimulus: blinks=2 sequence; second start with blinks=1 at cycle 10.
- Without macro: two pulses, done at cycle 41.
- With LED_BLINK_RETRIGGER_EN: led rises at cycle 11, one pulse only, done at cycle 31.
REQ-031 Scenario 6, back-to-back:
- Stimulus: start with blinks=1 held during the done cycle.
- Response: done=1 and acceptance in that same cycle; busy high again on the next cycle.

Source files
------------

// File: rtl/led_blink_driver_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : led_blink_driver_if
//  Description : Request/status bundle for led_blink_driver.
//                master : drives start/blinks, observes led/busy/done
//                slave  : the blink driver itself
//  Signals     : start  - request strobe
//                blinks - number of on/off cycles requested (4 bits)
//                led    - LED drive, high during the ON phase
//                busy   - high from acceptance until completion
//                done   - one-cycle completion pulse
//  Revision    : 1.0 - initial release
// ============================================================================
interface led_blink_driver_if;
   logic       start;
   logic [3:0] blinks;
   logic       led;
   logic       busy;
   logic       done;

   modport master (output start, output blinks, input led, input busy, input done);
   modport slave  (input start, input blinks, output led, output busy, output done);
endinterface
`default_nettype wire

// File: rtl/led_blink_driver.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : led_blink_driver
//  Description : Blinks an LED a requested number of times. Each blink is an
//                ON phase of ON_MS ticks followed by an OFF phase of OFF_MS
//                ticks, where a tick is TICK_DIV clock cycles. A phase length
//                of 0 is treated as 1 tick.
//  Ports       : CLOCK_50 - system clock, all state on its rising edge
//                reset    - asynchronous, active-high reset
//                bus      - led_blink_driver_if.slave (start, blinks in;
//                           led, busy, done out, all outputs registered)
//  Options     : LED_BLINK_RETRIGGER_EN - when defined, a start with
//                non-zero blinks during ON/OFF restarts the sequence;
//                when undefined such a start is ignored.
//  Revision    : 1.0 - initial release
// ============================================================================
module led_blink_driver #(
   parameter logic [15:0] TICK_DIV = 16'd50000,
   parameter logic [15:0] ON_MS    = 16'd250,
   parameter logic [15:0] OFF_MS   = 16'd250
) (
   input  wire                 CLOCK_50,
   input  wire                 reset,
   led_blink_driver_if.slave   bus
);

   // Last prescaler / ms-counter values; a zero-length phase collapses to 1 tick.
   localparam logic [15:0] C_TICK_LAST = TICK_DIV - 16'd1;
   localparam logic [15:0] C_ON_LAST   = (ON_MS  == 16'd0) ? 16'd0 : ON_MS  - 16'd1;
   localparam logic [15:0] C_OFF_LAST  = (OFF_MS == 16'd0) ? 16'd0 : OFF_MS - 16'd1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ON   = 2'd1,
      S_OFF  = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [15:0] presc_q, presc_d;
   logic [15:0] ms_q,    ms_d;
   logic [3:0]  rem_q,   rem_d;
   logic        led_q,   led_d;
   logic        busy_q,  busy_d;
   logic        done_q,  done_d;

   logic        tick;
   logic        accept;

   assign tick   = (presc_q == C_TICK_LAST);
   assign accept = bus.start && (bus.blinks != 4'd0);

   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         presc_q <= 16'd0;
         ms_q    <= 16'd0;
         rem_q   <= 4'd0;
         led_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         presc_q <= presc_d;
         ms_q    <= ms_d;
         rem_q   <= rem_d;
         led_q   <= led_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      presc_d = presc_q;
      ms_d    = ms_q;
      rem_d   = rem_q;
      done_d  = 1'b0;

      case (state_q)
         S_IDLE: begin
            presc_d = 16'd0;
            ms_d    = 16'd0;
            if (accept) begin
               rem_d   = bus.blinks;
               state_d = S_ON;
            end
         end

         S_ON: begin
            presc_d = tick ? 16'd0 : presc_q + 16'd1;
            if (tick) begin
               if (ms_q == C_ON_LAST) begin
                  ms_d    = 16'd0;
                  state_d = S_OFF;
               end else begin
                  ms_d = ms_q + 16'd1;
               end
            end
         end

         S_OFF: begin
            presc_d = tick ? 16'd0 : presc_q + 16'd1;
            if (tick) begin
               if (ms_q == C_OFF_LAST) begin
                  ms_d  = 16'd0;
                  rem_d = rem_q - 4'd1;
                  // rem_q==1 means this was the final blink of the request.
                  if (rem_q == 4'd1) begin
                     state_d = S_IDLE;
                     done_d  = 1'b1;
                  end else begin
                     state_d = S_ON;
                  end
               end else begin
                  ms_d = ms_q + 16'd1;
               end
            end
         end

         default: begin
            state_d = S_IDLE;
            presc_d = 16'd0;
            ms_d    = 16'd0;
            rem_d   = 4'd0;
         end
      endcase

`ifdef LED_BLINK_RETRIGGER_EN
      // A new request mid-sequence replaces the running one silently.
      if ((state_q != S_IDLE) && accept) begin
         rem_d   = bus.blinks;
         presc_d = 16'd0;
         ms_d    = 16'd0;
         state_d = S_ON;
         done_d  = 1'b0;
      end
`endif

      // Outputs are registered copies of the next state so they line up
      // with the state they describe.
      led_d  = (state_d == S_ON);
      busy_d = (state_d != S_IDLE);
   end

   assign bus.led  = led_q;
   assign bus.busy = busy_q;
   assign bus.done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_led_blink_driver.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_led_blink_driver
//  Description : Self-checking bench for led_blink_driver. Main DUT uses
//                TICK_DIV=4, ON_MS=2, OFF_MS=3 (ON=8, OFF=12 cycles); a
//                second DUT uses ON_MS=OFF_MS=0 with TICK_DIV=2.
//                Expected {led,busy,done} per cycle are queued when the
//                stimulus is applied and compared on the falling edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_led_blink_driver;

   localparam int ON_C  = 8;
   localparam int PER   = 20;
   localparam int ON0_C = 2;   // zero-length phases -> 1 tick of 2 cycles
   localparam int PER0  = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks   = 0;
   int   failures = 0;
   logic [2:0] sb[$];
   logic [2:0] ex;

   always #5 clk = ~clk;

   led_blink_driver_if bif ();
   led_blink_driver_if bif0 ();

   led_blink_driver #(.TICK_DIV(16'd4), .ON_MS(16'd2), .OFF_MS(16'd3)) dut (
      .CLOCK_50 (clk),
      .reset    (rst),
      .bus      (bif)
   );

   led_blink_driver #(.TICK_DIV(16'd2), .ON_MS(16'd0), .OFF_MS(16'd0)) dut0 (
      .CLOCK_50 (clk),
      .reset    (rst),
      .bus      (bif0)
   );

   // Expected {led,busy,done} at cycle c for a request of n blinks whose
   // start was sampled at the end of cycle s.
   function automatic logic [2:0] model(int c, int s, int n, int on_c, int per);
      int rel;
      rel = c - s;
      if (n == 0)                       return 3'b000;
      if (rel >= 1 && rel <= per * n)   return {(((rel - 1) % per) < on_c), 1'b1, 1'b0};
      if (rel == per * n + 1)           return 3'b001;
      return 3'b000;
   endfunction

   task automatic test_reset();
      @(negedge clk);
      @(negedge clk);
      checks++;
      if ({bif.led, bif.busy, bif.done} !== 3'b000) begin
         failures++;
         $display("FAIL reset_main got=%b exp=000", {bif.led, bif.busy, bif.done});
      end
      checks++;
      if ({bif0.led, bif0.busy, bif0.done} !== 3'b000) begin
         failures++;
         $display("FAIL reset_zero_ms got=%b exp=000", {bif0.led, bif0.busy, bif0.done});
      end
      rst = 1'b0;
      for (int c = 1; c <= 3; c++) sb.push_back(3'b000);
      for (int c = 1; c <= 3; c++) begin
         @(negedge clk);
         ex = sb.pop_front();
         checks++;
         if ({bif.led, bif.busy, bif.done} !== ex) begin
            failures++;
            $display("FAIL reset_idle cyc=%0d got=%b exp=%b", c, {bif.led, bif.busy, bif.done}, ex);
         end
      end
   endtask

   // Start with n blinks at cycle 0 and check ncyc cycles afterwards.
   task automatic test_blinks(input string name, input int n, input int ncyc);
      @(negedge clk);
      bif.start  = 1'b1;
      bif.blinks = n[3:0];
      for (int c = 1; c <= ncyc; c++) sb.push_back(model(c, 0, n, ON_C, PER));
      for (int c = 1; c <= ncyc; c++) begin
         @(negedge clk);
         if (c == 1) bif.start = 1'b0;
         ex = sb.pop_front();
         checks++;
         if ({bif.led, bif.busy, bif.done} !== ex) begin
            failures++;
            $display("FAIL %s cyc=%0d led/busy/done got=%b exp=%b", name, c, {bif.led, bif.busy, bif.done}, ex);
         end
      end
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      bif.start  = 1'b1;
      bif.blinks = 4'd2;
      for (int c = 1; c <= 5; c++) sb.push_back(model(c, 0, 2, ON_C, PER));
      for (int c = 1; c <= 5; c++) begin
         @(negedge clk);
         if (c == 1) bif.start = 1'b0;
         ex = sb.pop_front();
         checks++;
         if ({bif.led, bif.busy, bif.done} !== ex) begin
            failures++;
            $display("FAIL reset_mid_pre cyc=%0d got=%b exp=%b", c, {bif.led, bif.busy, bif.done}, ex);
         end
      end
      // Asserted away from any clock edge: outputs must fall immediately.
      rst = 1'b1;
      #1;
      checks++;
      if ({bif.led, bif.busy, bif.done} !== 3'b000) begin
         failures++;
         $display("FAIL reset_async got=%b exp=000", {bif.led, bif.busy, bif.done});
      end
      @(negedge clk);
      rst = 1'b0;
      for (int c = 1; c <= 45; c++) sb.push_back(3'b000);
      for (int c = 1; c <= 45; c++) begin
         @(negedge clk);
         ex = sb.pop_front();
         checks++;
         if ({bif.led, bif.busy, bif.done} !== ex) begin
            failures++;
            $display("FAIL reset_mid_post cyc=%0d got=%b exp=%b", c, {bif.led, bif.busy, bif.done}, ex);
         end
      end
      test_blinks("after_reset", 1, 25);
   endtask

   task automatic test_start_while_busy();
      @(negedge clk);
      bif.start  = 1'b1;
      bif.blinks = 4'd2;
      for (int c = 1; c <= 45; c++) begin
`ifdef LED_BLINK_RETRIGGER_EN
         sb.push_back((c <= 10) ? model(c, 0, 2, ON_C, PER) : model(c, 10, 1, ON_C, PER));
`else
         sb.push_back(model(c, 0, 2, ON_C, PER));
`endif
      end
      for (int c = 1; c <= 45; c++) begin
         @(negedge clk);
         ex = sb.pop_front();
         checks++;
         if ({bif.led, bif.busy, bif.done} !== ex) begin
            failures++;
            $display("FAIL start_busy cyc=%0d got=%b exp=%b", c, {bif.led, bif.busy, bif.done}, ex);
         end
         bif.start  = (c == 10);
         bif.blinks = (c == 10) ? 4'd1 : 4'd2;
      end
      bif.start = 1'b0;
   endtask

   task automatic test_back_to_back();
      @(negedge clk);
      bif.start  = 1'b1;
      bif.blinks = 4'd1;
      for (int c = 1; c <= 45; c++)
         sb.push_back(model(c, 0, 1, ON_C, PER) | model(c, 21, 1, ON_C, PER));
      for (int c = 1; c <= 45; c++) begin
         @(negedge clk);
         ex = sb.pop_front();
         checks++;
         if ({bif.led, bif.busy, bif.done} !== ex) begin
            failures++;
            $display("FAIL back_to_back cyc=%0d got=%b exp=%b", c, {bif.led, bif.busy, bif.done}, ex);
         end
         // Start held during the done cycle only.
         bif.start = (c == 21);
      end
      bif.start = 1'b0;
   endtask

   task automatic test_zero_ms();
      @(negedge clk);
      bif0.start  = 1'b1;
      bif0.blinks = 4'd2;
      for (int c = 1; c <= 12; c++) sb.push_back(model(c, 0, 2, ON0_C, PER0));
      for (int c = 1; c <= 12; c++) begin
         @(negedge clk);
         if (c == 1) bif0.start = 1'b0;
         ex = sb.pop_front();
         checks++;
         if ({bif0.led, bif0.busy, bif0.done} !== ex) begin
            failures++;
            $display("FAIL zero_ms cyc=%0d got=%b exp=%b", c, {bif0.led, bif0.busy, bif0.done}, ex);
         end
      end
   endtask

   initial begin
      bif.start   = 1'b0;
      bif.blinks  = 4'd0;
      bif0.start  = 1'b0;
      bif0.blinks = 4'd0;
      test_reset();
      test_blinks("single", 1, 25);
      test_blinks("three", 3, 65);
      test_blinks("zero", 0, 50);
      test_reset_mid();
      test_start_while_busy();
      test_back_to_back();
      test_blinks("max15", 15, 305);
      test_zero_ms();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
